uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single 56-bit UART TX packet port of the UART controller between three sources:
  - the ADS1292 sample stream (0xAA-headed 56-bit packets)
  - the MPR121 touch stream (0xBB-headed packets)
  - register-read responses from the core ('a'/'m' headed)
- Each source gets a one-entry holding slot.
- Register responses have strict priority. ADS and MPR streams are round-robin.
- Streaming sources are fire-and-forget: overruns keep the newest sample and are counted.
- Sits between the sensor/core packet builders and the UART controller TX port.

Parameters:
- DATA_W, 56, packet width; matches the UART controller TX word.
- ACK_TIMEOUT, 16'd1024, cycles to hold TX valid waiting for the downstream ready to drop before abandoning the packet.
- OVR_W, 8, width of each saturating overrun counter.

Ports:
- i_CLK  in  1  system clock
- i_RSTN  in  1  asynchronous, active-low reset
- i_ADS_DATA  in  56  ADS packet, forwarded unchanged
- i_ADS_VALID  in  1  one-cycle capture strobe; no backpressure
- i_MPR_DATA  in  56  MPR packet, forwarded unchanged
- i_MPR_VALID  in  1  one-cycle capture strobe; no backpressure
- i_REG_DATA  in  56  register-read response packet
- i_REG_VALID  in  1  response valid; transfer when high with o_REG_READY
- o_REG_READY  out  1  register slot empty
- o_UART_DATA_TX  out  56  packet to the UART controller
- o_UART_DATA_TX_VALID  out  1  packet offered
- i_UART_DATA_TX_READY  in  1  UART controller idle/ready; falls after it accepts a packet
- i_CLR_STATUS  in  1  clears overrun counters and the timeout flag
- o_ADS_OVERRUN  out  8  saturating count of ADS samples overwritten
- o_MPR_OVERRUN  out  8  saturating count of MPR samples overwritten
- o_ERR_TIMEOUT  out  1  sticky; a packet was abandoned
- o_BUSY  out  1  state != ST_IDLE, or any slot full

Behaviour:
- Reset values (i_RSTN=0, asynchronous):
  - all slots empty; o_REG_READY=1
  - o_UART_DATA_TX=0, o_UART_DATA_TX_VALID=0
  - counters 0; o_ERR_TIMEOUT=0; o_BUSY=0
  - state ST_IDLE; round-robin pointer = ADS
- All outputs are registered.
- Slot capture, ADS/MPR:
  - On i_x_VALID the slot loads data and is marked full.
  - If the slot was already full and is not being granted that cycle: new data overwrites it and the overrun counter increments, saturating at 255.
- Slot capture, REG:
  - Loads only when i_REG_VALID && o_REG_READY; never overwritten.
  - o_REG_READY = slot empty, registered; it falls the cycle after capture.
- Same-cycle grant and capture on one slot: the old data goes out; the slot stays full with the new data; no overrun counted.
- State ST_IDLE:
  - If any slot is full and i_UART_DATA_TX_READY=1, grant one slot. REG first, otherwise the round-robin pointer's slot if full, otherwise the other slot.
  - On grant: copy the slot to o_UART_DATA_TX, set VALID=1, empty the slot, clear the timeout counter, go to ST_ISSUE.
  - An ADS/MPR grant flips the pointer to the other stream. A REG grant leaves the pointer unchanged.
- State ST_ISSUE:
  - Hold VALID and DATA stable.
  - If i_UART_DATA_TX_READY=0: VALID<=0, go to ST_WAIT_DONE. The controller keeps ready high when it services an RX byte instead, so valid must persist until ready drops.
  - Otherwise increment the timeout counter. At ACK_TIMEOUT-1: VALID<=0, o_ERR_TIMEOUT<=1, packet discarded, go to ST_IDLE.
- State ST_WAIT_DONE: wait for i_UART_DATA_TX_READY=1, then go to ST_IDLE. No new grant in the cycle ready rises.
- Latency: a strobe at edge N makes the slot full at N+1. With the downstream idle, VALID is high after edge N+1. Best case is 2 clocks, strobe to VALID.
- Unused states go to ST_IDLE.
- i_CLR_STATUS has priority over a same-cycle overrun increment; counters read 0 afterwards.
- Reset mid-packet: VALID drops immediately and all slots are lost. The downstream finishes its own byte independently.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_W
  - header constants: 0xAA, 0xBB, 'a'=0x61, 'm'=0x6D, 'R'=0x52, 'S'=0x53
  - state encodings: ST_IDLE, ST_ISSUE, ST_WAIT_DONE
- Sub-module uart_tx_slot: single-entry buffer with a parameter OVERWRITE.
  - OVERWRITE=1 for ADS/MPR: overwrite plus saturating overrun counter.
  - OVERWRITE=0 for REG: ready/valid, no counter.
  - Instantiated three times.

Test Plan:
1. Single ADS strobe, data 0xAA0102030405FF, ready=1 → VALID high 2 clocks after the strobe with data intact. Ready forced low 1 clock later → VALID drops; no further grant until ready returns high.
2. ADS and MPR slots both full; ADS strobe at T, MPR strobe at T+1 (ADS ready at T+1, MPR at T+2); reg response at T+1; ready pulses complete each packet → grant order REG, ADS, MPR. Refill both streams → next order ADS, MPR (pointer alternates).
3. Downstream held busy (ready=0); three ADS strobes 0x..01/02/03 → o_ADS_OVERRUN=2. The packet sent is ...03. 300 overruns → counter=255. i_CLR_STATUS → 0.
4. Ready stuck at 1 after VALID → VALID held exactly 1024 cycles, then drops. o_ERR_TIMEOUT=1. The slot remains empty.
5. Reg capture while the arbiter is in ST_ISSUE → o_REG_READY=0 the next cycle. The response is granted first on the return to ST_IDLE, ahead of a full ADS slot.
6. i_RSTN low mid ST_ISSUE → outputs return to reset values asynchronously. After release, a pending strobe is serviced normally.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART TX path: packet width,
//                packet header bytes, arbiter state encoding and the
//                round-robin pointer type.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Packet width; matches the UART controller TX word.
    localparam int DATA_W = 56;

    // Packet header bytes used by the packet builders.
    localparam logic [7:0] HDR_ADS   = 8'hAA;
    localparam logic [7:0] HDR_MPR   = 8'hBB;
    localparam logic [7:0] HDR_REG_A = 8'h61;   // 'a'
    localparam logic [7:0] HDR_REG_M = 8'h6D;   // 'm'
    localparam logic [7:0] HDR_R     = 8'h52;   // 'R'
    localparam logic [7:0] HDR_S     = 8'h53;   // 'S'

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_t;

    // Which streaming source has the next turn.
    typedef enum logic [0:0] {
        RR_ADS = 1'b0,
        RR_MPR = 1'b1
    } rr_ptr_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_slot.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_slot
//  Description : Single-entry packet holding slot.
//                OVERWRITE=1: every strobe loads; a strobe into a full slot
//                that is not being granted overwrites it and bumps a
//                saturating overrun counter.
//                OVERWRITE=0: loads only when empty; never overwritten.
//  Ports       : i_CLK, i_RSTN     clock, async active-low reset
//                i_DATA, i_VALID   incoming packet and load strobe
//                i_GRANT           slot contents taken this cycle
//                i_CLR             clear the overrun counter
//                o_DATA, o_FULL    held packet and occupancy
//                o_FULL_NEXT       occupancy after the coming edge
//                o_OVERRUN         saturating overrun count
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_slot #(
    parameter bit OVERWRITE = 1'b1,
    parameter int DATA_W    = 56,
    parameter int OVR_W     = 8
) (
    input  logic              i_CLK,
    input  logic              i_RSTN,
    input  logic [DATA_W-1:0] i_DATA,
    input  logic              i_VALID,
    input  logic              i_GRANT,
    input  logic              i_CLR,
    output logic [DATA_W-1:0] o_DATA,
    output logic              o_FULL,
    output logic              o_FULL_NEXT,
    output logic [OVR_W-1:0]  o_OVERRUN
);

    localparam logic [OVR_W-1:0] c_OVR_MAX = '1;

    logic [DATA_W-1:0] r_data;
    logic              r_full;
    logic [OVR_W-1:0]  r_ovr;
    logic              w_load;
    logic              w_ovr_inc;
    logic              w_full_nxt;

    // A non-overwriting slot only accepts while empty.
    assign w_load    = i_VALID && (OVERWRITE || !r_full);
    // A grant in the same cycle frees the old entry, so nothing is lost.
    assign w_ovr_inc = OVERWRITE && i_VALID && r_full && !i_GRANT && (r_ovr != c_OVR_MAX);

    always_comb begin
        w_full_nxt = r_full;
        if (w_load) begin
            w_full_nxt = 1'b1;
        end else if (i_GRANT) begin
            w_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_data <= '0;
            r_full <= 1'b0;
            r_ovr  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_load) begin
                r_data <= i_DATA;
            end
            if (i_CLR) begin
                r_ovr <= '0;
            end else if (w_ovr_inc) begin
                r_ovr <= r_ovr + 1'b1;
            end
        end
    end

    assign o_DATA      = r_data;
    assign o_FULL      = r_full;
    assign o_FULL_NEXT = w_full_nxt;
    assign o_OVERRUN   = r_ovr;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares the UART controller TX packet port between the ADS
//                stream, the MPR stream and register-read responses.
//                Register responses have strict priority; the two streams
//                alternate round-robin.
//  Ports       : i_CLK, i_RSTN                 clock, async active-low reset
//                i_ADS_DATA/VALID              ADS packet + capture strobe
//                i_MPR_DATA/VALID              MPR packet + capture strobe
//                i_REG_DATA/VALID, o_REG_READY register response handshake
//                o_UART_DATA_TX[_VALID]        packet offered downstream
//                i_UART_DATA_TX_READY          downstream idle/ready
//                i_CLR_STATUS                  clears counters and timeout
//                o_ADS/MPR_OVERRUN             saturating overrun counts
//                o_ERR_TIMEOUT                 sticky abandoned-packet flag
//                o_BUSY                        packet in flight or slot full
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          DATA_W      = uart_pkg::DATA_W,
    parameter logic [15:0] ACK_TIMEOUT = 16'd1024,
    parameter int          OVR_W       = 8
) (
    input  logic              i_CLK,
    input  logic              i_RSTN,
    input  logic [DATA_W-1:0] i_ADS_DATA,
    input  logic              i_ADS_VALID,
    input  logic [DATA_W-1:0] i_MPR_DATA,
    input  logic              i_MPR_VALID,
    input  logic [DATA_W-1:0] i_REG_DATA,
    input  logic              i_REG_VALID,
    output logic              o_REG_READY,
    output logic [DATA_W-1:0] o_UART_DATA_TX,
    output logic              o_UART_DATA_TX_VALID,
    input  logic              i_UART_DATA_TX_READY,
    input  logic              i_CLR_STATUS,
    output logic [OVR_W-1:0]  o_ADS_OVERRUN,
    output logic [OVR_W-1:0]  o_MPR_OVERRUN,
    output logic              o_ERR_TIMEOUT,
    output logic              o_BUSY
);

    logic [DATA_W-1:0] w_ads_data, w_mpr_data, w_reg_data;
    logic              w_ads_full, w_mpr_full, w_reg_full;
    logic              w_ads_full_nxt, w_mpr_full_nxt, w_reg_full_nxt;
    logic              w_grant_ads, w_grant_mpr, w_grant_reg;
    logic [OVR_W-1:0]  w_reg_ovr_unused;

    tx_state_t         r_state, w_state_nxt;
    rr_ptr_t           r_rr, w_rr_nxt;
    logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;
    logic              r_tx_valid, w_tx_valid_nxt;
    logic [15:0]       r_timer, w_timer_nxt;
    logic              w_timeout_set;
    logic              r_err, r_reg_ready, r_busy;

    uart_tx_slot #(.OVERWRITE(1'b1), .DATA_W(DATA_W), .OVR_W(OVR_W)) u_slot_ads (
        .i_CLK(i_CLK), .i_RSTN(i_RSTN),
        .i_DATA(i_ADS_DATA), .i_VALID(i_ADS_VALID),
        .i_GRANT(w_grant_ads), .i_CLR(i_CLR_STATUS),
        .o_DATA(w_ads_data), .o_FULL(w_ads_full),
        .o_FULL_NEXT(w_ads_full_nxt), .o_OVERRUN(o_ADS_OVERRUN)
    );

    uart_tx_slot #(.OVERWRITE(1'b1), .DATA_W(DATA_W), .OVR_W(OVR_W)) u_slot_mpr (
        .i_CLK(i_CLK), .i_RSTN(i_RSTN),
        .i_DATA(i_MPR_DATA), .i_VALID(i_MPR_VALID),
        .i_GRANT(w_grant_mpr), .i_CLR(i_CLR_STATUS),
        .o_DATA(w_mpr_data), .o_FULL(w_mpr_full),
        .o_FULL_NEXT(w_mpr_full_nxt), .o_OVERRUN(o_MPR_OVERRUN)
    );

    // The register slot accepts only while empty, which is exactly when
    // o_REG_READY is high, so the handshake is honoured inside the slot.
    uart_tx_slot #(.OVERWRITE(1'b0), .DATA_W(DATA_W), .OVR_W(OVR_W)) u_slot_reg (
        .i_CLK(i_CLK), .i_RSTN(i_RSTN),
        .i_DATA(i_REG_DATA), .i_VALID(i_REG_VALID),
        .i_GRANT(w_grant_reg), .i_CLR(1'b0),
        .o_DATA(w_reg_data), .o_FULL(w_reg_full),
        .o_FULL_NEXT(w_reg_full_nxt), .o_OVERRUN(w_reg_ovr_unused)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_timer_nxt    = r_timer;
        w_timeout_set  = 1'b0;
        w_grant_ads    = 1'b0;
        w_grant_mpr    = 1'b0;
        w_grant_reg    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_UART_DATA_TX_READY) begin
                    if (w_reg_full) begin
                        w_grant_reg   = 1'b1;
                        w_tx_data_nxt = w_reg_data;
                    end else if (w_ads_full && (r_rr == RR_ADS || !w_mpr_full)) begin
                        w_grant_ads   = 1'b1;
                        w_tx_data_nxt = w_ads_data;
                        w_rr_nxt      = RR_MPR;
                    end else if (w_mpr_full) begin
                        w_grant_mpr   = 1'b1;
                        w_tx_data_nxt = w_mpr_data;
                        w_rr_nxt      = RR_ADS;
                    end
                    if (w_grant_reg || w_grant_ads || w_grant_mpr) begin
                        w_tx_valid_nxt = 1'b1;
                        w_timer_nxt    = '0;
                        w_state_nxt    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Ready staying high can mean the controller is busy with an
                // RX byte, so valid is held until ready actually drops.
                if (!i_UART_DATA_TX_READY) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = ST_WAIT_DONE;
                end else if (r_timer == ACK_TIMEOUT - 16'd1) begin
                    w_tx_valid_nxt = 1'b0;
                    w_timeout_set  = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (i_UART_DATA_TX_READY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_tx_valid_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_state     <= ST_IDLE;
            r_rr        <= RR_ADS;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_timer     <= '0;
            r_err       <= 1'b0;
            r_reg_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr        <= w_rr_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_timer     <= w_timer_nxt;
            if (i_CLR_STATUS) begin
                r_err <= 1'b0;
            end else if (w_timeout_set) begin
                r_err <= 1'b1;
            end
            r_reg_ready <= !w_reg_full_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE) || w_ads_full_nxt
                           || w_mpr_full_nxt || w_reg_full_nxt;
        end
    end

    assign o_REG_READY          = r_reg_ready;
    assign o_UART_DATA_TX       = r_tx_data;
    assign o_UART_DATA_TX_VALID = r_tx_valid;
    assign o_ERR_TIMEOUT        = r_err;
    assign o_BUSY               = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. A packet-level
//                model tracks slots, offers and counters; every falling edge
//                the DUT outputs are compared with it, and directed tests add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [55:0] ads_d = '0, mpr_d = '0, reg_d = '0;
    logic        ads_v = 1'b0, mpr_v = 1'b0, reg_v = 1'b0;
    logic        ready = 1'b1, clr = 1'b0;
    logic        reg_ready, tx_valid, err, busy;
    logic [55:0] tx_data;
    logic [7:0]  ads_ovr, mpr_ovr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .i_CLK(clk), .i_RSTN(rst_n),
        .i_ADS_DATA(ads_d), .i_ADS_VALID(ads_v),
        .i_MPR_DATA(mpr_d), .i_MPR_VALID(mpr_v),
        .i_REG_DATA(reg_d), .i_REG_VALID(reg_v),
        .o_REG_READY(reg_ready),
        .o_UART_DATA_TX(tx_data), .o_UART_DATA_TX_VALID(tx_valid),
        .i_UART_DATA_TX_READY(ready),
        .i_CLR_STATUS(clr),
        .o_ADS_OVERRUN(ads_ovr), .o_MPR_OVERRUN(mpr_ovr),
        .o_ERR_TIMEOUT(err), .o_BUSY(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    logic        m_ads_full = 0, m_mpr_full = 0, m_reg_full = 0;
    logic [55:0] m_ads_d = '0, m_mpr_d = '0, m_reg_d = '0, m_out = '0;
    int          m_ads_ovr = 0, m_mpr_ovr = 0;
    int          m_phase = 0;      // 0 free, 1 offering, 2 waiting for ready to return
    bit          m_ads_turn = 1;   // ADS has the next streaming turn
    logic        m_valid = 0, m_err = 0;
    int          m_held = 0;       // cycles the current offer has been visible

    task automatic model_reset();
        m_ads_full = 0; m_mpr_full = 0; m_reg_full = 0;
        m_ads_d = '0; m_mpr_d = '0; m_reg_d = '0; m_out = '0;
        m_ads_ovr = 0; m_mpr_ovr = 0; m_phase = 0; m_ads_turn = 1;
        m_valid = 0; m_err = 0; m_held = 0;
    endtask

    task automatic model_step();
        bit ga, gm, gr;
        ga = 0; gm = 0; gr = 0;
        case (m_phase)
            0: if (ready) begin
                if (m_reg_full) gr = 1;
                else if (m_ads_full && (m_ads_turn || !m_mpr_full)) ga = 1;
                else if (m_mpr_full) gm = 1;
                if (gr) m_out = m_reg_d;
                if (ga) begin m_out = m_ads_d; m_ads_turn = 0; end
                if (gm) begin m_out = m_mpr_d; m_ads_turn = 1; end
                if (ga || gm || gr) begin m_valid = 1; m_held = 1; m_phase = 1; end
            end
            1: if (!ready) begin
                m_valid = 0; m_phase = 2;
            end else if (m_held >= 1024) begin
                m_valid = 0; m_err = 1; m_phase = 0;
            end else begin
                m_held++;
            end
            default: if (ready) m_phase = 0;
        endcase
        if (ads_v) begin
            if (m_ads_full && !ga && m_ads_ovr < 255) m_ads_ovr++;
            m_ads_d = ads_d; m_ads_full = 1;
        end else if (ga) m_ads_full = 0;
        if (mpr_v) begin
            if (m_mpr_full && !gm && m_mpr_ovr < 255) m_mpr_ovr++;
            m_mpr_d = mpr_d; m_mpr_full = 1;
        end else if (gm) m_mpr_full = 0;
        if (reg_v && !m_reg_full) begin
            m_reg_d = reg_d; m_reg_full = 1;
        end else if (gr) m_reg_full = 0;
        if (clr) begin m_ads_ovr = 0; m_mpr_ovr = 0; m_err = 0; end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // One compare process against the model every falling edge.
    initial forever begin
        @(negedge clk);
        chk("m_valid", tx_valid, m_valid);
        chk("m_data", tx_data, m_out);
        chk("m_reg_ready", reg_ready, !m_reg_full);
        chk("m_ads_ovr", ads_ovr, m_ads_ovr[7:0]);
        chk("m_mpr_ovr", mpr_ovr, m_mpr_ovr[7:0]);
        chk("m_err", err, m_err);
        chk("m_busy", busy, (m_phase != 0) || m_ads_full || m_mpr_full || m_reg_full);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        ads_v = 0; mpr_v = 0; reg_v = 0; clr = 0; ready = 1;
        tick();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 64 && !tx_valid; i++) tick();
        if (!tx_valid) chk({nm, "_valid_timeout"}, 0, 1);
    endtask

    // Emulate the controller taking one packet: wait for valid, drop ready
    // for two cycles, then return to idle.
    task automatic complete_packet(output logic [55:0] d);
        wait_valid("complete");
        d = tx_data;
        ready = 0; tick(); tick();
        ready = 1; tick();
    endtask

    task automatic strobe_ads(input logic [55:0] d);
        ads_d = d; ads_v = 1; tick(); ads_v = 0;
    endtask

    logic [55:0] got;
    int          cnt;

    initial begin
        #1 rst_n = 0;
        tick(); tick();
        // reset state literals
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_reg_ready", reg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ads_ovr, 0);
        rst_n = 1;
        tick();

        // 1: single ADS strobe, two clocks to valid
        strobe_ads(56'hAA0102030405FF);
        chk("t1_valid_early", tx_valid, 0);
        tick();
        chk("t1_valid", tx_valid, 1);
        chk("t1_data", tx_data, 56'hAA0102030405FF);
        ready = 0; tick();
        chk("t1_valid_drop", tx_valid, 0);
        tick(); tick();
        chk("t1_no_regrant", tx_valid, 0);
        ready = 1; tick(); tick();
        chk("t1_idle", busy, 0);

        // 2: REG first, then round-robin ADS/MPR
        do_reset();
        ready = 0;
        ads_d = 56'hAA000000000011; ads_v = 1; tick(); ads_v = 0;
        mpr_d = 56'hBB000000000022; mpr_v = 1;
        reg_d = 56'h61000000000033; reg_v = 1; tick();
        mpr_v = 0; reg_v = 0; tick();
        ready = 1;
        complete_packet(got); chk("t2_first_reg", got, 56'h61000000000033);
        complete_packet(got); chk("t2_second_ads", got, 56'hAA000000000011);
        complete_packet(got); chk("t2_third_mpr", got, 56'hBB000000000022);
        ready = 0; tick();
        ads_d = 56'hAA000000000044; ads_v = 1;
        mpr_d = 56'hBB000000000055; mpr_v = 1; tick();
        ads_v = 0; mpr_v = 0;
        ready = 1;
        complete_packet(got); chk("t2_refill_ads", got, 56'hAA000000000044);
        complete_packet(got); chk("t2_refill_mpr", got, 56'hBB000000000055);

        // 3: overruns, saturation, clear
        do_reset();
        ready = 0;
        strobe_ads(56'hAA000000000001);
        strobe_ads(56'hAA000000000002);
        strobe_ads(56'hAA000000000003);
        tick();
        chk("t3_ovr2", ads_ovr, 2);
        ready = 1;
        complete_packet(got); chk("t3_newest", got, 56'hAA000000000003);
        ready = 0;
        ads_v = 1;
        for (int i = 0; i < 301; i++) begin ads_d = 56'hAA000000000100 + 56'(i); tick(); end
        ads_v = 0; tick();
        chk("t3_sat", ads_ovr, 255);
        clr = 1; tick(); clr = 0;
        chk("t3_clr", ads_ovr, 0);
        clr = 1; ads_v = 1; tick(); clr = 0; ads_v = 0;
        chk("t3_clr_prio", ads_ovr, 0);
        strobe_ads(56'hAA000000000009);
        chk("t3_after_clr", ads_ovr, 1);

        // 4: ready stuck high -> timeout after 1024 cycles
        do_reset();
        strobe_ads(56'hAA000000000444);
        wait_valid("t4");
        cnt = 0;
        while (tx_valid && cnt < 2000) begin cnt++; tick(); end
        chk("t4_hold_cycles", cnt, 1024);
        chk("t4_err", err, 1);
        chk("t4_slot_empty", busy, 0);
        clr = 1; tick(); clr = 0;
        chk("t4_err_clr", err, 0);

        // 5: REG captured during ISSUE wins over a full ADS slot
        do_reset();
        strobe_ads(56'hAA000000000555);
        wait_valid("t5");
        reg_d = 56'h6D000000000666; reg_v = 1;
        ads_d = 56'hAA000000000777; ads_v = 1; tick();
        reg_v = 0; ads_v = 0;
        chk("t5_reg_ready_low", reg_ready, 0);
        chk("t5_data_held", tx_data, 56'hAA000000000555);
        ready = 0; tick(); ready = 1;
        complete_packet(got); chk("t5_reg_first", got, 56'h6D000000000666);
        complete_packet(got); chk("t5_ads_next", got, 56'hAA000000000777);

        // 6: asynchronous reset mid-offer
        do_reset();
        strobe_ads(56'hAA000000000888);
        wait_valid("t6");
        #2 rst_n = 0;
        #1;
        chk("t6_async_valid", tx_valid, 0);
        chk("t6_async_data", tx_data, 0);
        chk("t6_async_ready", reg_ready, 1);
        chk("t6_async_busy", busy, 0);
        tick(); tick();
        rst_n = 1; tick();
        strobe_ads(56'hAA000000000999);
        tick();
        chk("t6_after_valid", tx_valid, 1);
        chk("t6_after_data", tx_data, 56'hAA000000000999);
        ready = 0; tick(); ready = 1; tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
